disp_mode_ctrl: RTL and testbench
=================================

DISP_MODE_CTRL -- requirements
Module: disp_mode_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; the only clock.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset sampled on posedge clk.
REQ-003 SHALL have port tick_1khz, input, 1, one-clk enable pulse every 1 ms.
REQ-004 SHALL have ports key_mode, key_sel, key_inc, input, 1 each, raw active-high buttons, asynchronous to clk.
REQ-005 SHALL have ports hour1, min1, sec1, input, 8 each, live time in BCD.
REQ-006 SHALL have ports ahour, amin, input, 8 each, alarm in BCD.
REQ-007 SHALL have ports swmin, swsec, input, 8 each, stopwatch value in BCD.
REQ-008 SHALL have ports disp_hour, disp_min, disp_sec, output, 8 each, BCD to the 8-digit scan driver.
REQ-009 SHALL have port blank, output, 3, per-field blank: bit2 hour, bit1 min, bit0 sec.
REQ-010 SHALL have port mode_st, output, 2: 0 TIME, 1 ALARM, 2 STOPWATCH.
REQ-011 SHALL have port editing, output, 1, high while a field is being edited.
REQ-012 SHALL have ports set_hour, set_min, set_sec, output, 8 each, edited BCD values.
REQ-013 SHALL have ports time_we, alarm_we, output, 1 each, one-clk commit strobes.

Function
REQ-014 SHALL pass each key through a 2-flop synchronizer, then a debouncer sampled on tick_1khz that accepts a new level after 20 consecutive equal samples.
REQ-015 SHALL generate a one-clk pulse on each debounced 0->1 edge; a release generates no pulse.
REQ-016 SHALL give same-clk pulses priority mode > sel > inc; lower-priority pulses in that clk are discarded.
REQ-017 SHALL, when not editing, advance mode_st on each mode pulse: TIME->ALARM->STOPWATCH->TIME.
REQ-018 SHALL, on a mode pulse while editing, abort the edit with no strobe and leave mode_st unchanged.
REQ-019 SHALL implement edit FSM states IDLE, E_HOUR, E_MIN, E_SEC.
REQ-020 SHALL, on a sel pulse in IDLE with mode TIME or ALARM, load set_* from the displayed source (TIME: hour1/min1/sec1; ALARM: ahour/amin/00) and enter E_HOUR.
REQ-021 SHALL ignore sel and inc pulses in STOPWATCH mode.
REQ-022 SHALL sequence sel pulses E_HOUR->E_MIN->E_SEC->IDLE in TIME mode and E_HOUR->E_MIN->IDLE in ALARM mode.
REQ-023 SHALL, on the transition to IDLE, pulse time_we (TIME) or alarm_we (ALARM) for exactly one clk with set_* stable during that clk.
REQ-024 SHALL, on an inc pulse, increment the edited field in BCD: hour 23->00, min/sec 59->00, low nibble 9 carries to the high nibble.
REQ-025 SHALL abort an edit after 10000 tick_1khz pulses with no key pulse; it SHALL return to IDLE with no strobe.
REQ-026 SHALL drive editing high in states E_HOUR, E_MIN and E_SEC only.
REQ-027 SHALL present these display sources: TIME non-editing hour1/min1/sec1; ALARM non-editing ahour/amin/8'h00; STOPWATCH 8'h00/swmin/swsec; any editing set_*.
REQ-028 SHALL use a 0..999 blink counter on tick_1khz that wraps and is cleared on entry to any edit state.
REQ-029 SHALL assert the blank bit of the edited field when blink count >= 500; all other blank bits SHALL be 0.
REQ-030 SHALL register all outputs, updating them one clk after the causing event.

Reset
REQ-031 SHALL, while rst_n=0 at posedge clk, set: mode_st=0, edit FSM=IDLE, editing=0, time_we=alarm_we=0, blank=0, set_*=8'h00, debouncers to released, all counters to 0.
REQ-032 SHALL, on reset mid-edit, discard the edit with no strobe.
REQ-033 SHALL drive disp_* = 8'h00 during reset and resume REQ-027 on the first clk after release.

Verification
REQ-034 SHALL cover: key_mode bounced 5 ms, then held 30 ms -> exactly one mode pulse; mode_st 0->1.
REQ-035 SHALL cover: TIME 23:59:58, sel, inc x1, sel, inc x1, sel, sel -> time_we one clk, set = 00:00:58.
REQ-036 SHALL cover: ALARM, sel, inc x3 from ahour=8'h09, sel, sel -> alarm_we, set_hour=8'h12.
REQ-037 SHALL cover: editing E_MIN, then mode pulse -> editing=0, no strobe, mode_st unchanged.
REQ-038 SHALL cover: editing E_HOUR, idle 10000 ticks -> abort, no strobe; blank[2] toggles every 500 ticks before the abort.
REQ-039 SHALL cover: rst_n low 1 clk during E_SEC -> all outputs at reset values next clk, no strobe.

Source files
------------

// File: rtl/disp_mode_ctrl.sv
// Display/mode controller for a BCD clock: key conditioning, mode selection,
// field editing with commit strobes, and blinking of the field being edited.
`timescale 1ns/1ps
module disp_mode_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1khz,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_inc,
    input  logic [7:0] hour1,
    input  logic [7:0] min1,
    input  logic [7:0] sec1,
    input  logic [7:0] ahour,
    input  logic [7:0] amin,
    input  logic [7:0] swmin,
    input  logic [7:0] swsec,
    output logic [7:0] disp_hour,
    output logic [7:0] disp_min,
    output logic [7:0] disp_sec,
    output logic [2:0] blank,
    output logic [1:0] mode_st,
    output logic       editing,
    output logic [7:0] set_hour,
    output logic [7:0] set_min,
    output logic [7:0] set_sec,
    output logic       time_we,
    output logic       alarm_we
);

    typedef enum logic [1:0] {IDLE, E_HOUR, E_MIN, E_SEC} edit_state_e;

    localparam logic [1:0]  MODE_TIME  = 2'd0;
    localparam logic [1:0]  MODE_ALARM = 2'd1;
    localparam logic [1:0]  MODE_SW    = 2'd2;
    localparam logic [4:0]  DB_LAST    = 5'd19;
    localparam logic [9:0]  BLINK_LAST = 10'd999;
    localparam logic [9:0]  BLINK_HALF = 10'd500;
    localparam logic [13:0] TMO_LAST   = 14'd9999;

    // Key vectors are ordered {inc, sel, mode}.
    logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d, rise;
    logic [2:0][4:0] db_cnt_q, db_cnt_d;
    logic            p_mode, p_sel, p_inc;

    edit_state_e state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  set_hour_q, set_hour_d, set_min_q, set_min_d, set_sec_q, set_sec_d;
    logic [7:0]  disp_hour_q, disp_hour_d, disp_min_q, disp_min_d, disp_sec_q, disp_sec_d;
    logic [2:0]  blank_q, blank_d;
    logic        editing_q, editing_d, time_we_q, time_we_d, alarm_we_q, alarm_we_d;
    logic [9:0]  blink_q, blink_d;
    logic [13:0] tmo_q, tmo_d;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        sync1_d  = {key_inc, key_sel, key_mode};
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        if (tick_1khz) begin
            for (int k = 0; k < 3; k++) begin
                if (sync2_q[k] == db_q[k]) begin
                    db_cnt_d[k] = '0;
                end else if (db_cnt_q[k] == DB_LAST) begin
                    db_d[k]     = sync2_q[k];
                    db_cnt_d[k] = '0;
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 5'd1;
                end
            end
        end
        rise   = db_d & ~db_q;
        p_mode = rise[0];
        p_sel  = rise[1] & ~rise[0];
        p_inc  = rise[2] & ~rise[1] & ~rise[0];
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        set_hour_d = set_hour_q;
        set_min_d  = set_min_q;
        set_sec_d  = set_sec_q;
        time_we_d  = 1'b0;
        alarm_we_d = 1'b0;
        blink_d    = blink_q;
        tmo_d      = tmo_q;
        if (tick_1khz) begin
            blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + 10'd1;
            tmo_d   = tmo_q + 14'd1;
        end

        if (p_mode) begin
            if (state_q == IDLE)
                mode_d = (mode_q == MODE_SW) ? MODE_TIME : mode_q + 2'd1;
            else
                state_d = IDLE;
        end else if (p_sel && mode_q != MODE_SW) begin
            case (state_q)
                IDLE: begin
                    state_d    = E_HOUR;
                    set_hour_d = (mode_q == MODE_ALARM) ? ahour : hour1;
                    set_min_d  = (mode_q == MODE_ALARM) ? amin  : min1;
                    set_sec_d  = (mode_q == MODE_ALARM) ? 8'h00 : sec1;
                end
                E_HOUR: state_d = E_MIN;
                E_MIN: begin
                    if (mode_q == MODE_ALARM) begin
                        state_d    = IDLE;
                        alarm_we_d = 1'b1;
                    end else begin
                        state_d = E_SEC;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    time_we_d = 1'b1;
                end
            endcase
        end else if (p_inc && mode_q != MODE_SW) begin
            case (state_q)
                E_HOUR:  set_hour_d = bcd_inc(set_hour_q, 8'h23);
                E_MIN:   set_min_d  = bcd_inc(set_min_q, 8'h59);
                E_SEC:   set_sec_d  = bcd_inc(set_sec_q, 8'h59);
                default: ;
            endcase
        end else if (state_q != IDLE && tick_1khz && tmo_q == TMO_LAST) begin
            state_d = IDLE;
        end

        // Inactivity timer restarts on any key press, including discarded ones.
        if (state_d == IDLE || rise != 3'b000)
            tmo_d = '0;
        if (state_d != state_q && state_d != IDLE)
            blink_d = '0;

        editing_d = (state_d != IDLE);
        blank_d   = 3'b000;
        if (blink_d >= BLINK_HALF) begin
            case (state_d)
                E_HOUR:  blank_d = 3'b100;
                E_MIN:   blank_d = 3'b010;
                E_SEC:   blank_d = 3'b001;
                default: blank_d = 3'b000;
            endcase
        end

        if (editing_d) begin
            disp_hour_d = set_hour_d;
            disp_min_d  = set_min_d;
            disp_sec_d  = set_sec_d;
        end else begin
            case (mode_d)
                MODE_ALARM: begin
                    disp_hour_d = ahour;
                    disp_min_d  = amin;
                    disp_sec_d  = 8'h00;
                end
                MODE_SW: begin
                    disp_hour_d = 8'h00;
                    disp_min_d  = swmin;
                    disp_sec_d  = swsec;
                end
                default: begin
                    disp_hour_d = hour1;
                    disp_min_d  = min1;
                    disp_sec_d  = sec1;
                end
            endcase
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_cnt_q    <= '0;
            state_q     <= IDLE;
            mode_q      <= MODE_TIME;
            set_hour_q  <= 8'h00;
            set_min_q   <= 8'h00;
            set_sec_q   <= 8'h00;
            disp_hour_q <= 8'h00;
            disp_min_q  <= 8'h00;
            disp_sec_q  <= 8'h00;
            blank_q     <= '0;
            editing_q   <= 1'b0;
            time_we_q   <= 1'b0;
            alarm_we_q  <= 1'b0;
            blink_q     <= '0;
            tmo_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            set_hour_q  <= set_hour_d;
            set_min_q   <= set_min_d;
            set_sec_q   <= set_sec_d;
            disp_hour_q <= disp_hour_d;
            disp_min_q  <= disp_min_d;
            disp_sec_q  <= disp_sec_d;
            blank_q     <= blank_d;
            editing_q   <= editing_d;
            time_we_q   <= time_we_d;
            alarm_we_q  <= alarm_we_d;
            blink_q     <= blink_d;
            tmo_q       <= tmo_d;
        end
    end

    assign disp_hour = disp_hour_q;
    assign disp_min  = disp_min_q;
    assign disp_sec  = disp_sec_q;
    assign blank     = blank_q;
    assign mode_st   = mode_q;
    assign editing   = editing_q;
    assign set_hour  = set_hour_q;
    assign set_min   = set_min_q;
    assign set_sec   = set_sec_q;
    assign time_we   = time_we_q;
    assign alarm_we  = alarm_we_q;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Self-checking bench for disp_mode_ctrl: directed scenarios plus random key
// presses compared against an integer-level model of modes, edits and commits.
`timescale 1ns/1ps
module tb_disp_mode_ctrl;

    localparam int TICK_DIV = 3;
    localparam int K_MODE = 0, K_SEL = 1, K_INC = 2;

    logic       clk, rst_n, tick_1khz, key_mode, key_sel, key_inc;
    logic [7:0] hour1, min1, sec1, ahour, amin, swmin, swsec;
    logic [7:0] disp_hour, disp_min, disp_sec, set_hour, set_min, set_sec;
    logic [2:0] blank;
    logic [1:0] mode_st;
    logic       editing, time_we, alarm_we;

    disp_mode_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick_1khz(tick_1khz),
        .key_mode(key_mode), .key_sel(key_sel), .key_inc(key_inc),
        .hour1(hour1), .min1(min1), .sec1(sec1), .ahour(ahour), .amin(amin),
        .swmin(swmin), .swsec(swsec),
        .disp_hour(disp_hour), .disp_min(disp_min), .disp_sec(disp_sec),
        .blank(blank), .mode_st(mode_st), .editing(editing),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .time_we(time_we), .alarm_we(alarm_we)
    );

    int n_checks = 0, n_errors = 0;
    int tick_cnt = 0;
    int tick_div = 0;

    // Observed strobe and mode-change history.
    int          twe_cnt = 0, awe_cnt = 0, we_long = 0, mode_changes = 0;
    logic [23:0] cap_t = '0, cap_a = '0;
    logic        twe_prev = 1'b0, awe_prev = 1'b0;
    logic [1:0]  mode_prev = 2'd0;

    // Reference model in plain integers.
    int          m_mode = 0, m_field = 0, m_h = 0, m_m = 0, m_s = 0, m_entry = 0;
    int          exp_twe = 0, exp_awe = 0;
    logic [23:0] exp_tval = '0, exp_aval = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick_1khz = 1'b0;
        forever begin
            @(negedge clk);
            tick_div++;
            if (tick_div == TICK_DIV) begin
                tick_div  = 0;
                tick_1khz = 1'b1;
                tick_cnt++;
            end else begin
                tick_1khz = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (time_we) begin
            twe_cnt++;
            cap_t = {set_hour, set_min, set_sec};
            if (twe_prev) we_long++;
        end
        if (alarm_we) begin
            awe_cnt++;
            cap_a = {set_hour, set_min, set_sec};
            if (awe_prev) we_long++;
        end
        twe_prev = time_we;
        awe_prev = alarm_we;
        if (mode_st !== mode_prev) mode_changes++;
        mode_prev = mode_st;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, got, exp, tick_cnt);
        end
    endtask

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic wait_ticks(input int n);
        int target;
        target = tick_cnt + n;
        while (tick_cnt < target) @(negedge clk);
    endtask

    task automatic wait_until_tick(input int t);
        while (tick_cnt < t) @(negedge clk);
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            K_MODE:  key_mode = v;
            K_SEL:   key_sel  = v;
            default: key_inc  = v;
        endcase
    endtask

    function automatic void model_reset();
        m_mode = 0; m_field = 0; m_h = 0; m_m = 0; m_s = 0;
    endfunction

    function automatic void model_press(input int k, input int ptick);
        case (k)
            K_MODE: begin
                if (m_field != 0) m_field = 0;
                else m_mode = (m_mode + 1) % 3;
            end
            K_SEL: begin
                if (m_mode != 2) begin
                    if (m_field == 0) begin
                        if (m_mode == 0) begin
                            m_h = from_bcd(hour1); m_m = from_bcd(min1); m_s = from_bcd(sec1);
                        end else begin
                            m_h = from_bcd(ahour); m_m = from_bcd(amin); m_s = 0;
                        end
                        m_field = 1; m_entry = ptick;
                    end else if (m_field == 1) begin
                        m_field = 2; m_entry = ptick;
                    end else if (m_field == 2 && m_mode == 1) begin
                        m_field = 0; exp_awe++;
                        exp_aval = {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)};
                    end else if (m_field == 2) begin
                        m_field = 3; m_entry = ptick;
                    end else begin
                        m_field = 0; exp_twe++;
                        exp_tval = {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)};
                    end
                end
            end
            default: begin
                if (m_mode != 2) begin
                    if (m_field == 1) m_h = (m_h + 1) % 24;
                    if (m_field == 2) m_m = (m_m + 1) % 60;
                    if (m_field == 3) m_s = (m_s + 1) % 60;
                end
            end
        endcase
    endfunction

    // Bounce, then a stable press; the debounced edge lands ~20 ticks into it.
    task automatic press(input int k, input int bounce, input int hold);
        int stable_tick;
        for (int i = 0; i < bounce; i++) begin
            set_key(k, (i % 2) == 0);
            wait_ticks(1);
        end
        set_key(k, 1'b0);
        wait_ticks(1);
        set_key(k, 1'b1);
        stable_tick = tick_cnt;
        wait_ticks(hold);
        model_press(k, stable_tick + 20);
        set_key(k, 1'b0);
        wait_ticks(25);
    endtask

    task automatic randomize_live();
        hour1 = to_bcd(int'($urandom_range(0, 23)));
        min1  = to_bcd(int'($urandom_range(0, 59)));
        sec1  = to_bcd(int'($urandom_range(0, 59)));
        ahour = to_bcd(int'($urandom_range(0, 23)));
        amin  = to_bcd(int'($urandom_range(0, 59)));
        swmin = to_bcd(int'($urandom_range(0, 59)));
        swsec = to_bcd(int'($urandom_range(0, 59)));
    endtask

    task automatic check_all(input string tag);
        logic [7:0] eh, em, es;
        logic [2:0] mask;
        int el;
        if (m_field != 0) begin
            eh = to_bcd(m_h); em = to_bcd(m_m); es = to_bcd(m_s);
        end else if (m_mode == 1) begin
            eh = ahour; em = amin; es = 8'h00;
        end else if (m_mode == 2) begin
            eh = 8'h00; em = swmin; es = swsec;
        end else begin
            eh = hour1; em = min1; es = sec1;
        end
        check({tag, ".disp_hour"}, disp_hour, eh);
        check({tag, ".disp_min"}, disp_min, em);
        check({tag, ".disp_sec"}, disp_sec, es);
        check({tag, ".mode_st"}, mode_st, m_mode);
        check({tag, ".editing"}, editing, m_field != 0);
        check({tag, ".set"}, {set_hour, set_min, set_sec}, {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)});
        check({tag, ".twe_cnt"}, twe_cnt, exp_twe);
        check({tag, ".awe_cnt"}, awe_cnt, exp_awe);
        check({tag, ".twe_val"}, cap_t, exp_tval);
        check({tag, ".awe_val"}, cap_a, exp_aval);
        check({tag, ".we_width"}, we_long, 0);
        if (m_field == 0) begin
            check({tag, ".blank"}, blank, 3'b000);
        end else begin
            el   = tick_cnt - m_entry;
            mask = (m_field == 1) ? 3'b100 : (m_field == 2) ? 3'b010 : 3'b001;
            if ((el % 500) >= 4 && (el % 500) <= 496)
                check({tag, ".blank"}, blank, ((el % 1000) >= 500) ? mask : 3'b000);
        end
    endtask

    initial begin
        int mc0, twe0, awe0;
        rst_n = 1'b0; key_mode = 1'b0; key_sel = 1'b0; key_inc = 1'b0;
        hour1 = 8'h12; min1 = 8'h34; sec1 = 8'h56;
        ahour = 8'h07; amin = 8'h30; swmin = 8'h01; swsec = 8'h02;
        repeat (3) @(negedge clk);
        check("rst.disp", {disp_hour, disp_min, disp_sec}, 24'h0);
        check("rst.ctrl", {mode_st, editing, blank, time_we, alarm_we}, 8'h0);
        check("rst.set", {set_hour, set_min, set_sec}, 24'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_rst");

        // Bounced mode key yields a single pulse.
        mc0 = mode_changes;
        press(K_MODE, 5, 30);
        check("req034.changes", mode_changes - mc0, 1);
        check("req034.mode", mode_st, 2'd1);
        check_all("req034");
        press(K_MODE, 2, 30);
        press(K_MODE, 2, 30);
        check_all("back_time");

        // Hour and minute roll over, seconds untouched.
        hour1 = 8'h23; min1 = 8'h59; sec1 = 8'h58;
        twe0 = twe_cnt;
        press(K_SEL, 3, 30); press(K_INC, 3, 30);
        press(K_SEL, 3, 30); press(K_INC, 3, 30);
        check_all("req035.mid");
        press(K_SEL, 3, 30); press(K_SEL, 3, 30);
        check("req035.we", twe_cnt - twe0, 1);
        check("req035.val", cap_t, 24'h000058);
        check_all("req035");

        // Alarm hour 09 -> 12 via three increments.
        press(K_MODE, 1, 30);
        ahour = 8'h09; amin = 8'h45;
        awe0 = awe_cnt;
        press(K_SEL, 2, 30);
        for (int i = 0; i < 3; i++) press(K_INC, 2, 30);
        press(K_SEL, 2, 30); press(K_SEL, 2, 30);
        check("req036.we", awe_cnt - awe0, 1);
        check("req036.val", cap_a, 24'h124500);
        check_all("req036");

        // Mode key aborts an edit in progress.
        press(K_MODE, 1, 30); press(K_MODE, 1, 30);
        press(K_SEL, 1, 30); press(K_SEL, 1, 30);
        check("req037.pre", editing, 1'b1);
        twe0 = twe_cnt; awe0 = awe_cnt;
        press(K_MODE, 1, 30);
        check("req037.editing", editing, 1'b0);
        check("req037.mode", mode_st, 2'd0);
        check("req037.strobes", (twe_cnt - twe0) + (awe_cnt - awe0), 0);
        check_all("req037");

        // Inactivity abort with blink observed along the way.
        press(K_SEL, 1, 30);
        twe0 = twe_cnt;
        for (int j = 0; j < 19; j++) begin
            wait_until_tick(m_entry + 250 + 500 * j);
            check("req038.blank", blank, (j % 2) ? 3'b100 : 3'b000);
        end
        wait_until_tick(m_entry + 9990);
        check("req038.before", editing, 1'b1);
        wait_until_tick(m_entry + 10010);
        check("req038.after", editing, 1'b0);
        check("req038.strobe", twe_cnt - twe0, 0);
        m_field = 0;
        check_all("req038");

        // One-clock reset in the middle of a seconds edit.
        press(K_SEL, 1, 30); press(K_SEL, 1, 30); press(K_SEL, 1, 30);
        check_all("req039.pre");
        twe0 = twe_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check("req039.disp", {disp_hour, disp_min, disp_sec}, 24'h0);
        check("req039.ctrl", {mode_st, editing, blank, time_we, alarm_we}, 8'h0);
        check("req039.set", {set_hour, set_min, set_sec}, 24'h0);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("req039.strobe", twe_cnt - twe0, 0);
        check_all("req039.post");

        for (int i = 0; i < 30; i++) begin
            int r, k;
            if ($urandom_range(0, 3) == 0) randomize_live();
            r = int'($urandom_range(0, 9));
            k = (r < 2) ? K_MODE : (r < 6) ? K_SEL : K_INC;
            press(k, int'($urandom_range(0, 8)), 24 + int'($urandom_range(0, 300)));
            check_all("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at tick %0d", tick_cnt);
        $fatal(1);
    end

endmodule
